// File: rtl/input_buffer_pkg.sv
// Shared types and width helpers for the input buffer arbiter slice.
package input_buffer_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int src_id_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // One extra bit so a full buffer count is representable for any depth.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/input_buffer_arbiter_if.sv
// Source-side and buffer-side signals of the input buffer arbiter.
interface input_buffer_arbiter_if import input_buffer_pkg::*; #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4
) ();
    localparam int SRC_ID_W = src_id_w(NUM_SRC);

    logic [NUM_SRC-1:0]                          src_valid;
    logic [NUM_SRC-1:0]                          src_eof;
    logic [NUM_SRC-1:0][N-1:0][DATA_WIDTH-1:0]   src_vector;
    logic [NUM_SRC-1:0]                          src_ready;
    logic                                        ib_deq;
    logic                                        enqueue;
    logic                                        eof_out;
    logic [N-1:0][DATA_WIDTH-1:0]                vector_out;
    logic [SRC_ID_W-1:0]                         src_id_out;
    logic                                        busy;

    modport slave (
        input  src_valid, src_eof, src_vector, ib_deq,
        output src_ready, enqueue, eof_out, vector_out, src_id_out, busy
    );

    modport master (
        output src_valid, src_eof, src_vector, ib_deq,
        input  src_ready, enqueue, eof_out, vector_out, src_id_out, busy
    );
endinterface

// File: rtl/input_buffer_arbiter_rr_select.sv
// Combinational round-robin pick: first set request bit at or after ptr, with wrap.
module rr_select #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);
    logic [NUM_SRC-1:0] rot;
    logic [31:0]        off;

    // rot[k] is the request sitting k positions after ptr.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
        logic [ID_W-1:0] pos;
        assign pos     = ID_W'((32'(ptr) + 32'(gi)) % NUM_SRC);
        assign rot[gi] = req[pos];
    end

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = 32'(k);
                found = 1'b1;
            end
        end
    end

    assign idx = ID_W'((32'(ptr) + off) % NUM_SRC);
endmodule

// File: rtl/input_buffer_arbiter.sv
// Frame-level round-robin arbiter feeding one input buffer with credit-based flow control.
// Optional per-source accepted-beat counters: define INPUT_BUFFER_ARB_STATS_EN.
module input_buffer_arbiter import input_buffer_pkg::*; #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int IB_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input_buffer_arbiter_if.slave bus
`ifdef INPUT_BUFFER_ARB_STATS_EN
    ,
    output logic [NUM_SRC-1:0][31:0] beat_count
`endif
);
    localparam int SRC_ID_W = src_id_w(NUM_SRC);
    localparam int CREDIT_W = credit_w(IB_DEPTH);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(IB_DEPTH - 1);
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_LOCKED = LOCKED;

    logic [0:0]                   state_reg;
    logic [SRC_ID_W-1:0]          grant_reg;
    logic [SRC_ID_W-1:0]          rr_ptr_reg;
    logic [SRC_ID_W-1:0]          rr_ptr_next;
    logic [CREDIT_W-1:0]          credits_reg;
    logic [CREDIT_W-1:0]          credits_next;
    logic                         enqueue_reg;
    logic                         eof_out_reg;
    logic [N-1:0][DATA_WIDTH-1:0] vector_out_reg;
    logic [SRC_ID_W-1:0]          src_id_out_reg;

    logic [SRC_ID_W-1:0] sel_idx;
    logic                sel_found;
    logic                locked;
    logic                has_credit;
    logic                accept;
    logic                grant_eof;
    logic                deq_eff;

    rr_select #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (SRC_ID_W)
    ) u_rr_select (
        .req   (bus.src_valid),
        .ptr   (rr_ptr_reg),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign locked     = (state_reg == ST_LOCKED);
    assign has_credit = (credits_reg < CREDIT_MAX);
    assign accept     = locked && has_credit && bus.src_valid[grant_reg];
    assign grant_eof  = bus.src_eof[grant_reg];
    // A pop against an empty count is a downstream protocol error; drop it.
    assign deq_eff    = bus.ib_deq && (credits_reg != '0);

    assign rr_ptr_next = (grant_reg == SRC_ID_W'(NUM_SRC - 1)) ? '0 : grant_reg + SRC_ID_W'(1);

    always_comb begin
        credits_next = credits_reg;
        if (accept && !deq_eff) begin
            credits_next = credits_reg + CREDIT_W'(1);
        end else if (!accept && deq_eff) begin
            credits_next = credits_reg - CREDIT_W'(1);
        end
    end

    // Ready depends only on registered state so sources may wait on it safely.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
        assign bus.src_ready[gi] = locked && has_credit && (grant_reg == SRC_ID_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            rr_ptr_reg     <= '0;
            credits_reg    <= '0;
            enqueue_reg    <= 1'b0;
            eof_out_reg    <= 1'b0;
            vector_out_reg <= '0;
            src_id_out_reg <= '0;
        end else begin
            credits_reg <= credits_next;
            enqueue_reg <= accept;
            eof_out_reg <= accept && grant_eof;
            if (accept) begin
                vector_out_reg <= bus.src_vector[grant_reg];
                src_id_out_reg <= grant_reg;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant_reg <= sel_idx;
                        state_reg <= ST_LOCKED;
                    end
                end
                default: begin
                    if (accept && grant_eof) begin
                        state_reg  <= ST_IDLE;
                        rr_ptr_reg <= rr_ptr_next;
                    end
                end
            endcase
        end
    end

    assign bus.enqueue    = enqueue_reg;
    assign bus.eof_out    = eof_out_reg;
    assign bus.vector_out = vector_out_reg;
    assign bus.src_id_out = src_id_out_reg;
    assign bus.busy       = locked;

`ifdef INPUT_BUFFER_ARB_STATS_EN
    logic [31:0] count_reg [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stats
        always_ff @(posedge clk) begin
            if (rst) begin
                count_reg[gi] <= '0;
            end else if (accept && (grant_reg == SRC_ID_W'(gi)) && (count_reg[gi] != '1)) begin
                count_reg[gi] <= count_reg[gi] + 32'd1;
            end
        end
        assign beat_count[gi] = count_reg[gi];
    end
`endif
endmodule

// File: doc/input_buffer_arbiter.md
# input_buffer_arbiter

Frame-level round-robin arbiter that shares one input buffer between NUM_SRC trace sources. Sits directly in front of the input buffer: drives its `enqueue`/`eof_in`/`vector_in` and tracks buffer occupancy with a credit counter so the buffer is never written while full. A source owns the buffer from its first beat through its EOF beat, so vectors from different sources never interleave within a frame.

## Interface
- `N`, 8, vector lanes
- `DATA_WIDTH`, 32, bits per lane
- `NUM_SRC`, 4, number of requesting sources (≥2)
- `IB_DEPTH`, 4, input buffer depth; usable capacity is IB_DEPTH-1 entries
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `src_valid`  in  [NUM_SRC]  source i presents a beat
- `src_eof`  in  [NUM_SRC]  beat is last of source i's frame
- `src_vector`  in  [NUM_SRC][N][DATA_WIDTH]  per-source vector
- `src_ready`  out  [NUM_SRC]  beat of source i accepted this cycle when valid&ready
- `ib_deq`  in  1  pulse: input buffer popped one entry this cycle
- `enqueue`  out  1  write strobe to input buffer
- `eof_out`  out  1  EOF of the written beat
- `vector_out`  out  [N][DATA_WIDTH]  written vector
- `src_id_out`  out  clog2(NUM_SRC)  source of the written beat
- `busy`  out  1  state is LOCKED

## Operation
- States: IDLE, LOCKED. Reset → IDLE, `grant`=0, `rr_ptr`=0, `credits`=0.
- IDLE: if any `src_valid`, select first i with src_valid[i] scanning rr_ptr, rr_ptr+1, … mod NUM_SRC; register grant=i; → LOCKED next cycle. No ready asserted in IDLE.
- LOCKED: `src_ready[grant]` = (credits < IB_DEPTH-1); all other ready bits 0. src_ready is combinational from registered state and credits only (never from src_valid).
- Accept = src_valid[grant] & src_ready[grant]. On accept with src_eof[grant]=1: → IDLE, rr_ptr ← (grant+1) mod NUM_SRC.
- Source dropping valid mid-frame: stay LOCKED (no timeout).
- Credits: +1 on accept, −1 on ib_deq, unchanged when both occur. ib_deq with credits=0 ignored (bench assertion flags it). Width clog2(IB_DEPTH)+1, never exceeds IB_DEPTH-1.
- Outputs registered: on accept, next cycle enqueue=1, vector_out/eof_out/src_id_out = accepted beat; otherwise enqueue=0, eof_out=0, data held.

## Timing
- Reset values: enqueue=0, eof_out=0, vector_out=0, src_id_out=0, busy=0, src_ready=0.
- Arbitration latency: 1 cycle IDLE→LOCKED; first beat accepted earliest 1 cycle after valid seen in IDLE.
- Frame-to-frame: one idle bubble per EOF (IDLE cycle).
- Accept→enqueue: 1 cycle. Sustained 1 beat/cycle while credits allow.
- Full: credits=IB_DEPTH-1 → ready=0 that cycle; ib_deq raises ready the following cycle (credits registered).
- Reset mid-frame: immediate return to IDLE, credits cleared, partial frame abandoned; downstream buffer must be reset together.

## Configuration
- `INPUT_BUFFER_ARB_STATS_EN` defined: adds output `beat_count` [NUM_SRC][32], per-source count of accepted beats, saturating at 2^32−1, cleared by rst.
- Undefined: port and counters absent; all other behaviour identical.

## Structure
- Shared package `input_buffer_pkg`: `arb_state_t` enum {IDLE, LOCKED}, `SRC_ID_W` = clog2(NUM_SRC) function, credit width helper.
- One sub-module: `rr_select` — combinational first-set-bit search from rr_ptr with wrap, returns index and found flag.

## Test plan
- Single source 0, frame of 3 beats, IB_DEPTH=4, ib_deq held 1 → grant at cycle 1, enqueue cycles 3-5, eof_out=1 on cycle 5, src_id_out=0.
- Sources 0 and 2 valid continuously, 2-beat frames → grant order 0,2,0,2; no interleaving within a frame; one bubble between frames.
- ib_deq held 0, source 1 sends 5-beat frame, IB_DEPTH=4 → exactly 3 enqueues then src_ready[1]=0; one ib_deq pulse → 4th beat accepted next cycle.
- Accept and ib_deq same cycle at credits=2 → credits stay 2, ready stays 1.
- rst asserted mid-frame (after 2 of 4 beats) → next cycle busy=0, enqueue=0, credits=0, rr_ptr=0.
- With `INPUT_BUFFER_ARB_STATS_EN`: 5 beats from src 3, 2 from src 1 → beat_count[3]=5, beat_count[1]=2, others 0.
